ldm_stm_ctrl: RTL and testbench

Multi-cycle sequencer for ARMv4 block data transfer (LDM/STM). It latches the decoded register list, addressing mode and base value, then steps the load/store datapath through one register per enabled cycle. For every transfer it presents the register index and word address. It holds the fetch/decode pipeline until the final transfer and produces the base writeback value. It sits beside the SWP hold controller in the execute stage and shares the same `en` stall convention.

---
 rtl/ldm_stm_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_ldm_stm_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ldm_stm_ctrl.sv
// rtl/ldm_stm_ctrl.sv - LDM/STM block transfer sequencer, one register per enabled cycle
// Optional user-bank signalling is compiled in with `LDM_USER_BANK_EN.
module ldm_stm_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        i_start,
  input  logic [15:0] i_reglist,
  input  logic        i_p,
  input  logic        i_u,
  input  logic        i_w,
  input  logic        i_l,
  input  logic        i_s,
  input  logic [3:0]  i_base_idx,
  input  logic [31:0] i_base,
  output logic        o_hold,
  output logic        o_xfer,
  output logic [3:0]  o_reg_idx,
  output logic [31:0] o_addr,
  output logic        o_load,
  output logic        o_last,
  output logic        o_wb_en,
  output logic [3:0]  o_wb_idx,
  output logic [31:0] o_wb_value,
  output logic        o_user_bank
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t      state, state_d;
  logic [15:0] rem_list, rem_list_d;
  logic [31:0] next_addr, next_addr_d;
  logic        wb_ok, wb_ok_d;
  logic        ub_ok, ub_ok_d;
  logic        hold_d, xfer_d, load_d, last_d, wb_en_d, user_bank_d;
  logic [3:0]  reg_idx_d, wb_idx_d;
  logic [31:0] addr_d, wb_value_d;

  logic [4:0]  reg_count;
  logic [31:0] four_n;
  logic [31:0] start_addr;
  logic        start_ub_ok;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] r;
    r = 5'd0;
    for (int i = 0; i < 16; i++) r = r + {4'd0, v[i]};
    return r;
  endfunction

  function automatic logic [3:0] lowest_bit(input logic [15:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 15; i >= 0; i--) if (v[i]) r = i[3:0];
    return r;
  endfunction

  assign reg_count = popcount16(i_reglist);
  assign four_n    = {25'd0, reg_count, 2'b00};

  // Lowest register always maps to the lowest address, so every mode counts upward from here.
  always_comb begin
    case ({i_p, i_u})
      2'b01:   start_addr = i_base;
      2'b11:   start_addr = i_base + 32'd4;
      2'b00:   start_addr = i_base - four_n + 32'd4;
      default: start_addr = i_base - four_n;
    endcase
  end

`ifdef LDM_USER_BANK_EN
  // LDM^ with PC in the list is an SPSR restore, not a user-bank access.
  assign start_ub_ok = i_s && (!i_l || !i_reglist[15]);
`else
  logic unused_s;
  assign unused_s    = i_s;
  assign start_ub_ok = 1'b0;
`endif

  always_comb begin
    state_d     = state;
    rem_list_d  = rem_list;
    next_addr_d = next_addr;
    wb_ok_d     = wb_ok;
    ub_ok_d     = ub_ok;
    hold_d      = o_hold;
    xfer_d      = o_xfer;
    reg_idx_d   = o_reg_idx;
    addr_d      = o_addr;
    load_d      = o_load;
    last_d      = o_last;
    wb_en_d     = o_wb_en;
    wb_idx_d    = o_wb_idx;
    wb_value_d  = o_wb_value;
    user_bank_d = o_user_bank;

    case (state)
      IDLE: begin
        hold_d      = 1'b0;
        xfer_d      = 1'b0;
        last_d      = 1'b0;
        wb_en_d     = 1'b0;
        user_bank_d = 1'b0;
        if (i_start && (i_reglist != 16'd0)) begin
          state_d     = XFER;
          rem_list_d  = i_reglist & (i_reglist - 16'd1);
          reg_idx_d   = lowest_bit(i_reglist);
          addr_d      = {start_addr[31:2], 2'b00};
          next_addr_d = {start_addr[31:2], 2'b00} + 32'd4;
          load_d      = i_l;
          wb_idx_d    = i_base_idx;
          wb_value_d  = i_u ? (i_base + four_n) : (i_base - four_n);
          wb_ok_d     = i_w && !(i_l && i_reglist[i_base_idx]);
          ub_ok_d     = start_ub_ok;
          xfer_d      = 1'b1;
          last_d      = (rem_list_d == 16'd0);
          hold_d      = !last_d;
          wb_en_d     = last_d && wb_ok_d;
          user_bank_d = start_ub_ok;
        end
      end
      XFER: begin
        if (o_last) begin
          state_d     = IDLE;
          hold_d      = 1'b0;
          xfer_d      = 1'b0;
          last_d      = 1'b0;
          wb_en_d     = 1'b0;
          user_bank_d = 1'b0;
        end else begin
          reg_idx_d   = lowest_bit(rem_list);
          addr_d      = next_addr;
          next_addr_d = next_addr + 32'd4;
          rem_list_d  = rem_list & (rem_list - 16'd1);
          last_d      = (rem_list_d == 16'd0);
          hold_d      = !last_d;
          wb_en_d     = last_d && wb_ok;
          user_bank_d = ub_ok;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rem_list    <= 16'd0;
      next_addr   <= 32'd0;
      wb_ok       <= 1'b0;
      ub_ok       <= 1'b0;
      o_hold      <= 1'b0;
      o_xfer      <= 1'b0;
      o_reg_idx   <= 4'd0;
      o_addr      <= 32'd0;
      o_load      <= 1'b0;
      o_last      <= 1'b0;
      o_wb_en     <= 1'b0;
      o_wb_idx    <= 4'd0;
      o_wb_value  <= 32'd0;
      o_user_bank <= 1'b0;
    end else if (en) begin
      state       <= state_d;
      rem_list    <= rem_list_d;
      next_addr   <= next_addr_d;
      wb_ok       <= wb_ok_d;
      ub_ok       <= ub_ok_d;
      o_hold      <= hold_d;
      o_xfer      <= xfer_d;
      o_reg_idx   <= reg_idx_d;
      o_addr      <= addr_d;
      o_load      <= load_d;
      o_last      <= last_d;
      o_wb_en     <= wb_en_d;
      o_wb_idx    <= wb_idx_d;
      o_wb_value  <= wb_value_d;
      o_user_bank <= user_bank_d;
    end
  end

endmodule

// File: tb/tb_ldm_stm_ctrl.sv
// tb/tb_ldm_stm_ctrl.sv - directed self-checking bench for ldm_stm_ctrl
module tb_ldm_stm_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        i_start;
  logic [15:0] i_reglist;
  logic        i_p, i_u, i_w, i_l, i_s;
  logic [3:0]  i_base_idx;
  logic [31:0] i_base;
  logic        o_hold, o_xfer, o_load, o_last, o_wb_en, o_user_bank;
  logic [3:0]  o_reg_idx, o_wb_idx;
  logic [31:0] o_addr, o_wb_value;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef LDM_USER_BANK_EN
  localparam logic UB_EXP = 1'b1;
`else
  localparam logic UB_EXP = 1'b0;
`endif

  always #5 clk = ~clk;

  ldm_stm_ctrl dut (
    .clk(clk), .rst_n(rst_n), .en(en), .i_start(i_start), .i_reglist(i_reglist),
    .i_p(i_p), .i_u(i_u), .i_w(i_w), .i_l(i_l), .i_s(i_s),
    .i_base_idx(i_base_idx), .i_base(i_base),
    .o_hold(o_hold), .o_xfer(o_xfer), .o_reg_idx(o_reg_idx), .o_addr(o_addr),
    .o_load(o_load), .o_last(o_last), .o_wb_en(o_wb_en), .o_wb_idx(o_wb_idx),
    .o_wb_value(o_wb_value), .o_user_bank(o_user_bank)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where transfer 0 is visible.
  task automatic launch(input logic [15:0] list, input logic [31:0] base, input logic p,
                        input logic u, input logic w, input logic l, input logic s,
                        input logic [3:0] rn);
    i_reglist  = list;
    i_base     = base;
    i_p = p; i_u = u; i_w = w; i_l = l; i_s = s;
    i_base_idx = rn;
    i_start    = 1'b1;
    @(negedge clk);
    i_start    = 1'b0;
  endtask

  task automatic expect_xfer(input string tag, input logic [3:0] idx, input logic [31:0] addr,
                             input logic hold, input logic last, input logic wbe);
    check({tag, "_xfer"}, {31'd0, o_xfer}, 32'd1);
    check({tag, "_idx"},  {28'd0, o_reg_idx}, {28'd0, idx});
    check({tag, "_addr"}, o_addr, addr);
    check({tag, "_hold"}, {31'd0, o_hold}, {31'd0, hold});
    check({tag, "_last"}, {31'd0, o_last}, {31'd0, last});
    check({tag, "_wben"}, {31'd0, o_wb_en}, {31'd0, wbe});
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_xfer"}, {31'd0, o_xfer}, 32'd0);
    check({tag, "_hold"}, {31'd0, o_hold}, 32'd0);
    check({tag, "_last"}, {31'd0, o_last}, 32'd0);
    check({tag, "_wben"}, {31'd0, o_wb_en}, 32'd0);
    check({tag, "_ub"},   {31'd0, o_user_bank}, 32'd0);
  endtask

  task automatic expect_all_zero(input string tag);
    expect_idle(tag);
    check({tag, "_idx"},   {28'd0, o_reg_idx}, 32'd0);
    check({tag, "_addr"},  o_addr, 32'd0);
    check({tag, "_load"},  {31'd0, o_load}, 32'd0);
    check({tag, "_wbidx"}, {28'd0, o_wb_idx}, 32'd0);
    check({tag, "_wbval"}, o_wb_value, 32'd0);
  endtask

  logic [3:0]  t2_idx  [2] = '{4'd0, 4'd15};
  logic [31:0] t2_addr [2] = '{32'h1FF8, 32'h1FFC};

  initial begin
    rst_n = 1'b0; en = 1'b1; i_start = 1'b0; i_reglist = 16'd0;
    i_p = 0; i_u = 0; i_w = 0; i_l = 0; i_s = 0; i_base_idx = 4'd0; i_base = 32'd0;
    repeat (2) @(negedge clk);
    expect_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // LDMIA base 0x1000, R0-R3, writeback
    launch(16'h000F, 32'h1000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd5);
    for (int k = 0; k < 4; k++) begin
      expect_xfer($sformatf("ldmia_%0d", k), k[3:0], 32'h1000 + 32'(4 * k), k < 3, k == 3, k == 3);
      check($sformatf("ldmia_load_%0d", k), {31'd0, o_load}, 32'd1);
      @(negedge clk);
    end
    check("ldmia_wbval", o_wb_value, 32'h1010);
    check("ldmia_wbidx", {28'd0, o_wb_idx}, 32'd5);
    expect_idle("ldmia_end");

    // STMDB base 0x2000, R0 and R15
    launch(16'h8001, 32'h2000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd13);
    for (int k = 0; k < 2; k++) begin
      expect_xfer($sformatf("stmdb_%0d", k), t2_idx[k], t2_addr[k], k == 0, k == 1, k == 1);
      check($sformatf("stmdb_load_%0d", k), {31'd0, o_load}, 32'd0);
      if (k == 1) check("stmdb_wbval", o_wb_value, 32'h1FF8);
      @(negedge clk);
    end
    expect_idle("stmdb_end");

    // LDMIB single register, base in list suppresses writeback
    launch(16'h0004, 32'h3000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2);
    expect_xfer("ldmib", 4'd2, 32'h3004, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    expect_idle("ldmib_end");

    // STMDA R1-R3 with a stall on the second transfer
    launch(16'h000E, 32'h4000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd9);
    expect_xfer("stmda_0", 4'd1, 32'h3FF8, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    expect_xfer("stmda_1", 4'd2, 32'h3FFC, 1'b1, 1'b0, 1'b0);
    en = 1'b0;
    repeat (2) @(negedge clk);
    expect_xfer("stmda_stall", 4'd2, 32'h3FFC, 1'b1, 1'b0, 1'b0);
    en = 1'b1;
    @(negedge clk);
    expect_xfer("stmda_2", 4'd3, 32'h4000, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    expect_idle("stmda_end");

    // STMDB wrapping below zero
    launch(16'h0003, 32'h0000_0004, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
    expect_xfer("wrap_0", 4'd0, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    expect_xfer("wrap_1", 4'd1, 32'h0000_0000, 1'b0, 1'b1, 1'b1);
    check("wrap_wbval", o_wb_value, 32'hFFFF_FFFC);
    @(negedge clk);
    expect_idle("wrap_end");

    // 16-register LDM cut by reset on the third transfer
    launch(16'hFFFF, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    repeat (2) @(negedge clk);
    expect_xfer("ldm16_2", 4'd2, 32'h8, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    expect_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    launch(16'h0000, 32'h5000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1);
    for (int k = 0; k < 3; k++) begin
      expect_idle($sformatf("empty_%0d", k));
      @(negedge clk);
    end
    check("empty_addr", o_addr, 32'd0);

    // STMIA with S=1: user bank only when the option is built in
    launch(16'h0003, 32'h6000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1);
    for (int k = 0; k < 2; k++) begin
      expect_xfer($sformatf("stm_s_%0d", k), k[3:0], 32'h6000 + 32'(4 * k), k == 0, k == 1, 1'b0);
      check($sformatf("stm_s_ub_%0d", k), {31'd0, o_user_bank}, {31'd0, UB_EXP});
      @(negedge clk);
    end
    expect_idle("stm_s_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
